// File: rtl/uart_frame_monitor.sv
// uart_frame_monitor: passive UART receiver that reports each frame's data word, parity error, framing error and a running frame count.
//   clk, reset    : clock and synchronous active-high reset
//   rx            : observed serial line (idle high, LSB first)
//   data          : last received word; data_valid strobes one cycle per completed frame
//   parity_err    : parity mismatch; frame_err : a stop bit was sampled low (both qualified by data_valid)
//   frame_count   : completed frames since reset (wraps); busy : a frame is in progress
module uart_frame_monitor #(
  parameter int BIT_CYCLES = 6,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int COUNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic [COUNT_W-1:0]   frame_count,
  output logic                 busy
);
  localparam int HALF = BIT_CYCLES / 2;
  localparam int BW = $clog2(DATA_BITS);
  typedef enum logic [2:0] {ST_ARM, ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
  state_t               state_q;
  logic [7:0]           cnt_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] sh_q, data_q;
  logic                 par_q, stop_q, ferr_q, dv_q, perr_q, frame_err_q;
  logic [COUNT_W-1:0]   fc_q;
  logic                 at_bit, stop_bad, last_stop;
  // cnt_q equals the number of cycles since the previous sample, so a full bit period ends a bit
  assign at_bit = cnt_q == 8'(BIT_CYCLES);
  assign stop_bad = ferr_q | ~rx;
  assign last_stop = stop_q == 1'(STOP_BITS - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ARM;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      par_q <= 1'b0;
      stop_q <= 1'b0;
      ferr_q <= 1'b0;
      dv_q <= 1'b0;
      perr_q <= 1'b0;
      frame_err_q <= 1'b0;
      fc_q <= '0;
    end else begin
      dv_q <= 1'b0;
      cnt_q <= at_bit ? 8'd1 : cnt_q + 8'd1;
      case (state_q)
        ST_ARM: if (rx) state_q <= ST_IDLE;
        ST_IDLE: begin
          cnt_q <= 8'd1;
          // a falling edge seen during the strobe cycle is deliberately ignored
          if (!rx && !dv_q) state_q <= ST_START;
        end
        ST_START: begin
          cnt_q <= cnt_q == 8'(HALF) ? 8'd1 : cnt_q + 8'd1;
          bit_q <= '0;
          par_q <= 1'b0;
          stop_q <= 1'b0;
          ferr_q <= 1'b0;
          if (cnt_q == 8'(HALF)) state_q <= rx ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (at_bit) begin
          sh_q <= {rx, sh_q[DATA_BITS-1:1]};
          bit_q <= bit_q + 1'b1;
          if (bit_q == BW'(DATA_BITS - 1)) state_q <= PARITY != 0 ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: if (at_bit) begin
          par_q <= rx;
          state_q <= ST_STOP;
        end
        ST_STOP: if (at_bit) begin
          stop_q <= 1'b1;
          ferr_q <= stop_bad;
          if (last_stop) begin
            data_q <= sh_q;
            dv_q <= 1'b1;
            perr_q <= (PARITY != 0) && ((^sh_q ^ par_q) != (PARITY == 2));
            frame_err_q <= stop_bad;
            fc_q <= fc_q + 1'b1;
            // a framing error may mean the line is stuck low, so wait for it to return high
            state_q <= stop_bad ? ST_ARM : ST_IDLE;
          end
        end
        default: state_q <= ST_ARM;
      endcase
    end
  end
  assign data = data_q;
  assign data_valid = dv_q;
  assign parity_err = perr_q;
  assign frame_err = frame_err_q;
  assign frame_count = fc_q;
  assign busy = state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
endmodule

// File: tb/tb_uart_frame_monitor.sv
module tb_uart_frame_monitor;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] rx = 4'hf;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic [3:0] dv, pe, fe, bz;
  logic [7:0] fc0, fc1, fc3;
  logic [1:0] fc2;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  int exp_fc[4] = '{0, 0, 0, 0};
  int BC[4] = '{6, 6, 6, 9};
  int DB[4] = '{8, 8, 8, 7};
  int PAR[4] = '{0, 1, 0, 2};
  int SB[4] = '{1, 1, 2, 1};
  int CW[4] = '{8, 8, 2, 8};
  typedef struct packed {int u; int t; logic [8:0] d; logic pe; logic fe;} ev_t;
  ev_t evq[$], expq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_frame_monitor u0 (.clk(clk), .reset(reset), .rx(rx[0]), .data(d0), .data_valid(dv[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .frame_count(fc0), .busy(bz[0]));
  uart_frame_monitor #(.PARITY(1)) u1 (.clk(clk), .reset(reset), .rx(rx[1]), .data(d1), .data_valid(dv[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .frame_count(fc1), .busy(bz[1]));
  uart_frame_monitor #(.STOP_BITS(2), .COUNT_W(2)) u2 (.clk(clk), .reset(reset), .rx(rx[2]), .data(d2),
    .data_valid(dv[2]), .parity_err(pe[2]), .frame_err(fe[2]), .frame_count(fc2), .busy(bz[2]));
  uart_frame_monitor #(.BIT_CYCLES(9), .DATA_BITS(7), .PARITY(2)) u3 (.clk(clk), .reset(reset), .rx(rx[3]),
    .data(d3), .data_valid(dv[3]), .parity_err(pe[3]), .frame_err(fe[3]), .frame_count(fc3), .busy(bz[3]));

  function automatic logic [8:0] dat(int u);
    return u == 0 ? {1'b0, d0} : u == 1 ? {1'b0, d1} : u == 2 ? {1'b0, d2} : {2'b0, d3};
  endfunction

  function automatic logic [7:0] fcnt(int u);
    return u == 0 ? fc0 : u == 1 ? fc1 : u == 2 ? {6'b0, fc2} : fc3;
  endfunction

  always @(negedge clk)
    for (int u = 0; u < 4; u++)
      if (dv[u]) begin
        ev_t e;
        e.u = u; e.t = cyc; e.d = dat(u); e.pe = pe[u]; e.fe = fe[u];
        evq.push_back(e);
      end

  // Drives one frame on line u starting at the next edge and predicts its report.
  // late = 1 when the start edge coincides with the previous strobe and is seen one cycle later.
  task automatic send(input int u, input logic [8:0] d, input logic pbit, input logic [1:0] stp,
                      input bit glitch, input bit trunc, input int late);
    int h, nb, ls;
    logic lv[$];
    logic [8:0] dm;
    ev_t e;
    h = BC[u] / 2;
    nb = 1 + DB[u] + (PAR[u] != 0 ? 1 : 0) + SB[u];
    ls = h + (nb - 1) * BC[u];
    dm = d & 9'((1 << DB[u]) - 1);
    lv.push_back(1'b0);
    for (int i = 0; i < DB[u]; i++) lv.push_back(dm[i]);
    if (PAR[u] != 0) lv.push_back(pbit);
    for (int i = 0; i < SB[u]; i++) lv.push_back(stp[i]);
    e.u = u;
    e.t = cyc + ls + 1 + late;
    e.d = dm;
    e.pe = PAR[u] != 0 && (($countones(dm) + int'(pbit)) % 2 != (PAR[u] == 2 ? 1 : 0));
    e.fe = stp[0] == 1'b0 || (SB[u] == 2 && stp[1] == 1'b0);
    expq.push_back(e);
    exp_fc[u]++;
    for (int n = 0; n < (trunc ? ls + 1 : nb * BC[u]); n++) begin
      rx[u] = (glitch && n > 0 && n < ls && n % BC[u] != h) ? 1'($urandom_range(0, 1)) : lv[n / BC[u]];
      @(posedge clk); #1;
    end
    rx[u] = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) begin
      n_cmp++;
      if ({dv[u], pe[u], fe[u], bz[u]} !== 4'b0 || dat(u) !== 9'd0 || fcnt(u) !== 8'd0) begin
        n_bad++;
        $display("FAIL reset_u%0d dv/pe/fe/busy=%b data=%h count=%0d, required all zero",
                 u, {dv[u], pe[u], fe[u], bz[u]}, dat(u), fcnt(u));
      end
    end
    reset = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bz !== 4'b0) begin n_bad++; $display("FAIL arm_low_line busy=%b required 0000", bz); end
    end
    rx = 4'hf;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (evq.size() !== 0) begin n_bad++; $display("FAIL reset_strobes got %0d required 0", evq.size()); end
  endtask

  task automatic test_single();
    int s;
    s = cyc;
    send(0, 9'h48, 1'b0, 2'b11, 1'b0, 1'b0, 0);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (evq.size() !== 1) begin
      n_bad++; $display("FAIL single_strobes got %0d required 1", evq.size());
    end else begin
      n_cmp++;
      if (evq[0].t - s !== 58 || evq[0].d !== 9'h48 || evq[0].pe !== 1'b0 || evq[0].fe !== 1'b0) begin
        n_bad++;
        $display("FAIL single_frame cycle=%0d data=%h pe=%b fe=%b, required 58 48 0 0",
                 evq[0].t - s, evq[0].d, evq[0].pe, evq[0].fe);
      end
    end
    n_cmp++;
    if (fc0 !== 8'd1) begin n_bad++; $display("FAIL single_count got %0d required 1", fc0); end
    evq.delete();
    expq.delete();
  endtask

  task automatic test_hello();
    logic [7:0] hw[11] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64};
    for (int i = 0; i < 11; i++) send(0, {1'b0, hw[i]}, 1'b0, 2'b11, 1'b0, 1'b0, 0);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (evq.size() !== expq.size()) begin
      n_bad++; $display("FAIL hello_strobes got %0d required %0d", evq.size(), expq.size());
    end
    while (evq.size() > 0 && expq.size() > 0) begin
      ev_t a, b;
      a = evq.pop_front(); b = expq.pop_front(); n_cmp++;
      if (a !== b) begin
        n_bad++;
        $display("FAIL hello_frame u%0d got t=%0d d=%h pe=%b fe=%b required t=%0d d=%h pe=%b fe=%b",
                 b.u, a.t, a.d, a.pe, a.fe, b.t, b.d, b.pe, b.fe);
      end
    end
    evq.delete();
    expq.delete();
    n_cmp++;
    if (fcnt(0) !== 8'(exp_fc[0])) begin n_bad++; $display("FAIL hello_count got %0d required %0d", fcnt(0), exp_fc[0]); end
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (d0 !== 8'h64 || pe[0] !== 1'b0 || fe[0] !== 1'b0) begin
      n_bad++; $display("FAIL hello_hold data=%h pe=%b fe=%b required 64 0 0", d0, pe[0], fe[0]);
    end
  endtask

  task automatic test_parity();
    send(1, 9'h07, 1'b0, 2'b11, 1'b0, 1'b0, 0);
    send(1, 9'h07, 1'b1, 2'b11, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++)
      send(1, 9'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 2'b11, 1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++)
      send(3, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 2'b11, 1'b1, 1'b0, 0);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (evq.size() !== expq.size()) begin
      n_bad++; $display("FAIL parity_strobes got %0d required %0d", evq.size(), expq.size());
    end
    while (evq.size() > 0 && expq.size() > 0) begin
      ev_t a, b;
      a = evq.pop_front(); b = expq.pop_front(); n_cmp++;
      if (a !== b) begin
        n_bad++;
        $display("FAIL parity_frame u%0d got t=%0d d=%h pe=%b fe=%b required t=%0d d=%h pe=%b fe=%b",
                 b.u, a.t, a.d, a.pe, a.fe, b.t, b.d, b.pe, b.fe);
      end
    end
    evq.delete();
    expq.delete();
    for (int u = 1; u < 4; u += 2) begin
      n_cmp++;
      if (fcnt(u) !== 8'(exp_fc[u])) begin n_bad++; $display("FAIL parity_count_u%0d got %0d required %0d", u, fcnt(u), exp_fc[u]); end
    end
  endtask

  task automatic test_stop_err();
    send(2, 9'hA5, 1'b0, 2'b01, 1'b0, 1'b0, 0);
    rx[2] = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bz[2] !== 1'b0) begin n_bad++; $display("FAIL stop_err_arm busy=%b required 0", bz[2]); end
    end
    rx[2] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(2, 9'($urandom_range(0, 255)), 1'b0, 2'b11, 1'b0, 1'b0, 0);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (evq.size() !== expq.size()) begin
      n_bad++; $display("FAIL stop_err_strobes got %0d required %0d", evq.size(), expq.size());
    end
    while (evq.size() > 0 && expq.size() > 0) begin
      ev_t a, b;
      a = evq.pop_front(); b = expq.pop_front(); n_cmp++;
      if (a !== b) begin
        n_bad++;
        $display("FAIL stop_err_frame u%0d got t=%0d d=%h pe=%b fe=%b required t=%0d d=%h pe=%b fe=%b",
                 b.u, a.t, a.d, a.pe, a.fe, b.t, b.d, b.pe, b.fe);
      end
    end
    evq.delete();
    expq.delete();
    n_cmp++;
    if (fc2 !== 2'(exp_fc[2] % 4) || fc2 !== 2'd1) begin
      n_bad++; $display("FAIL wrap_count got %0d required 1", fc2);
    end
  endtask

  task automatic test_false_start();
    rx[0] = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bz[0] !== 1'b1) begin n_bad++; $display("FAIL false_start_busy got %b required 1", bz[0]); end
    @(posedge clk); #1;
    rx[0] = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (bz[0] !== 1'b0 || evq.size() !== 0 || fc0 !== 8'(exp_fc[0])) begin
      n_bad++;
      $display("FAIL false_start busy=%b strobes=%0d count=%0d required 0 0 %0d", bz[0], evq.size(), fc0, exp_fc[0]);
    end
  endtask

  task automatic test_back_to_back();
    send(0, 9'($urandom_range(0, 255)), 1'b0, 2'b11, 1'b0, 1'b1, 0);
    send(0, 9'($urandom_range(0, 255)), 1'b0, 2'b11, 1'b0, 1'b0, 1);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (evq.size() !== expq.size()) begin
      n_bad++; $display("FAIL b2b_strobes got %0d required %0d", evq.size(), expq.size());
    end
    while (evq.size() > 0 && expq.size() > 0) begin
      ev_t a, b;
      a = evq.pop_front(); b = expq.pop_front(); n_cmp++;
      if (a !== b) begin
        n_bad++;
        $display("FAIL b2b_frame u%0d got t=%0d d=%h pe=%b fe=%b required t=%0d d=%h pe=%b fe=%b",
                 b.u, a.t, a.d, a.pe, a.fe, b.t, b.d, b.pe, b.fe);
      end
    end
    evq.delete();
    expq.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    v = 8'h55;
    for (int n = 0; n < 30; n++) begin
      rx[0] = n < 6 ? 1'b0 : v[n / 6 - 1];
      @(posedge clk); #1;
    end
    reset = 1'b1;
    rx[0] = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (dv[0] !== 1'b0 || bz !== 4'b0 || fc0 !== 8'd0 || d0 !== 8'd0) begin
      n_bad++; $display("FAIL reset_mid dv=%b busy=%b count=%0d data=%h required 0 0000 0 00", dv[0], bz, fc0, d0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int u = 0; u < 4; u++) exp_fc[u] = 0;
    repeat (10) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bz[0] !== 1'b0) begin n_bad++; $display("FAIL reset_mid_arm busy=%b required 0", bz[0]); end
    end
    rx[0] = 1'b1;
    @(posedge clk); #1;
    send(0, 9'h3C, 1'b0, 2'b11, 1'b0, 1'b0, 0);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (evq.size() !== expq.size()) begin
      n_bad++; $display("FAIL reset_mid_strobes got %0d required %0d", evq.size(), expq.size());
    end
    while (evq.size() > 0 && expq.size() > 0) begin
      ev_t a, b;
      a = evq.pop_front(); b = expq.pop_front(); n_cmp++;
      if (a !== b) begin
        n_bad++;
        $display("FAIL reset_mid_frame u%0d got t=%0d d=%h pe=%b fe=%b required t=%0d d=%h pe=%b fe=%b",
                 b.u, a.t, a.d, a.pe, a.fe, b.t, b.d, b.pe, b.fe);
      end
    end
    evq.delete();
    expq.delete();
    n_cmp++;
    if (fc0 !== 8'd1) begin n_bad++; $display("FAIL reset_mid_count got %0d required 1", fc0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hello();
    test_parity();
    test_stop_err();
    test_false_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_frame_monitor.md
UART_FRAME_MONITOR -- requirements
Module: uart_frame_monitor

Interface
REQ-001 Parameter BIT_CYCLES, default 6: clock cycles per serial bit; legal 4..255.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal 5..9.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter STOP_BITS, default 1: legal 1 or 2.
REQ-005 Parameter COUNT_W, default 8: width of frame counter.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 rx  input  1  serial line under observation, idle high, LSB first.
REQ-009 data  output  DATA_BITS  last received data word.
REQ-010 data_valid  output  1  one-cycle strobe: frame complete.
REQ-011 parity_err  output  1  parity mismatch in frame; qualified by data_valid.
REQ-012 frame_err  output  1  stop bit sampled 0; qualified by data_valid.
REQ-013 frame_count  output  COUNT_W  completed frames since reset.
REQ-014 busy  output  1  high in states START, DATA, PARITY, STOP.

Function
REQ-015 States SHALL be ARM, IDLE, START, DATA, PARITY, STOP.
REQ-016 ARM: wait for rx == 1; rx == 1 -> IDLE next cycle.
REQ-017 IDLE: rx == 0 -> START; that cycle defines frame cycle 0; bit-cycle counter cleared.
REQ-018 HALF = BIT_CYCLES/2 (integer division); sample k SHALL be taken at frame cycle HALF + k*BIT_CYCLES.
REQ-019 Sample 0 is start bit; sample 0 == 1 -> false start: return to IDLE, no strobe, no counter change.
REQ-020 Samples 1..DATA_BITS SHALL fill data bits 0..DATA_BITS-1 (LSB first); data register updated only at frame completion.
REQ-021 PARITY != 0: next sample is parity bit; even: XOR(data, parity) must be 0; odd: must be 1; else parity_err = 1. PARITY == 0: PARITY state skipped, parity_err = 0.
REQ-022 STOP: STOP_BITS samples follow; any sampled 0 -> frame_err = 1.
REQ-023 data_valid SHALL assert for exactly one cycle, in the cycle after the last stop sample, with data, parity_err, frame_err valid that cycle.
REQ-024 data, parity_err, frame_err SHALL hold until next data_valid or reset.
REQ-025 frame_count SHALL increment by 1 on every data_valid (errored frames included), wrapping modulo 2^COUNT_W.
REQ-026 After data_valid: frame_err == 0 -> IDLE; frame_err == 1 -> ARM (no new start until line returns high).
REQ-027 rx transitions between sample points SHALL be ignored; only sample-point values matter.
REQ-028 Earliest next frame: falling edge detectable in the cycle data_valid is high is ignored; detection begins the following cycle.

Reset
REQ-029 reset == 1 at a rising edge: state ARM, data = 0, data_valid = 0, parity_err = 0, frame_err = 0, frame_count = 0, busy = 0.
REQ-030 reset SHALL override every other update in the same cycle, including mid-frame; aborted frame produces no strobe and no count.
REQ-031 After reset deasserts, reception SHALL start only after rx is seen high (ARM -> IDLE).

Verification
REQ-032 Defaults, frame 0x48 (start at cycle 0, 6 cycles/bit, stop 1) -> data_valid at cycle 58 only, data = 0x48, both errs 0, frame_count = 1.
REQ-033 Eleven frames "Hello World" back-to-back -> eleven strobes, data sequence 0x48 65 6C 6C 6F 20 57 6F 72 6C 64, frame_count = 11.
REQ-034 PARITY = 1, frame 0x07 with parity bit 0 -> data_valid, data = 0x07, parity_err = 1; with parity bit 1 -> parity_err = 0.
REQ-035 STOP_BITS = 2, second stop bit 0 -> frame_err = 1 at cycle 64, state ARM; next falling edge ignored until rx high seen.
REQ-036 rx low pulse of 2 cycles in IDLE -> false start at sample 0, no data_valid, frame_count unchanged.
REQ-037 reset asserted at frame cycle 30 -> no data_valid, frame_count = 0, busy = 0 next cycle; COUNT_W = 2 with 5 frames -> frame_count = 1.
